sparse_capture_sequencer: RTL and testbench

SPARSE_CAPTURE_SEQUENCER -- requirements
Module: sparse_capture_sequencer

---
 rtl/sparse_capture_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_sparse_capture_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_capture_sequencer.sv
// ----------------------------------------------------------------------------
// sparse_capture_sequencer
//
// Purpose: sequences a capture window over NUM_STREAMS external buffers.
// The window opens on a start command or on a masked auxiliary trigger
// rising edge while armed. It closes on a stop command or on any buffer-full
// flag. The buffered streams are then drained in index order onto a single
// output stream, followed by one trailer word that holds the per-stream beat
// counts.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cmd_*             command channel {arm, start, stop}; always ready
//   mask_*            aux trigger enable mask; accepted only in IDLE
//   aux_trigger       external trigger levels (rising edge detected)
//   stream_full       per-stream buffer-full flags (close the window)
//   buffer_start/stop single-cycle capture control pulses
//   capture_done      high while draining (READOUT) and in TRAILER
//   state             FSM state code
//   in_*              packed per-stream readout inputs, stream k at slice k
//   out_*             merged readout stream plus trailer word
// ----------------------------------------------------------------------------
module sparse_capture_sequencer #(
    parameter int unsigned NUM_STREAMS = 2,
    parameter int unsigned DWIDTH      = 128,
    parameter int unsigned NUM_AUX     = 4,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2:0]                    cmd_data,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [NUM_AUX-1:0]            mask_data,
    input  logic                          mask_valid,
    output logic                          mask_ready,
    input  logic [NUM_AUX-1:0]            aux_trigger,
    input  logic [NUM_STREAMS-1:0]        stream_full,
    output logic                          buffer_start,
    output logic                          buffer_stop,
    output logic                          capture_done,
    output logic [2:0]                    state,
    input  logic [NUM_STREAMS*DWIDTH-1:0] in_data,
    input  logic [NUM_STREAMS-1:0]        in_valid,
    input  logic [NUM_STREAMS-1:0]        in_last,
    output logic [NUM_STREAMS-1:0]        in_ready,
    output logic [DWIDTH-1:0]             out_data,
    output logic                          out_valid,
    output logic                          out_last,
    input  logic                          out_ready
);

    localparam int unsigned SEL_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_STREAMS - 1);

    // Trailer word must be able to carry every counter side by side.
    generate
        if (NUM_STREAMS * COUNT_WIDTH > DWIDTH) begin : g_bad_params
            $error("sparse_capture_sequencer: NUM_STREAMS*COUNT_WIDTH exceeds DWIDTH");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_READOUT = 3'd3,
        ST_TRAILER = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [NUM_AUX-1:0]      mask_q;
    logic [NUM_AUX-1:0]      aux_d_q;
    logic [COUNT_WIDTH-1:0]  cnt_q [NUM_STREAMS];
    logic                    buffer_start_q;
    logic                    buffer_stop_q;

    logic                    cmd_stop;
    logic                    cmd_start;
    logic                    cmd_arm;
    logic                    trig;
    logic                    enter_capture;
    logic                    leave_capture;
    logic                    beat_hs;
    logic [DWIDTH-1:0]       sel_data;
    logic                    sel_valid;
    logic                    sel_last;
    logic [DWIDTH-1:0]       trailer_word;

    // Command decode: stop dominates, masking arm/start in the same word.
    assign cmd_stop  = cmd_valid & cmd_data[0];
    assign cmd_start = cmd_valid & cmd_data[1] & ~cmd_data[0];
    assign cmd_arm   = cmd_valid & cmd_data[2] & ~cmd_data[0];

    // Masked rising-edge trigger.
    assign trig = |(aux_trigger & ~aux_d_q & mask_q);

    // Select the stream currently being drained.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int k = 0; k < int'(NUM_STREAMS); k++) begin
            if (SEL_W'(k) == sel_q) begin
                sel_data  = in_data[k*DWIDTH +: DWIDTH];
                sel_valid = in_valid[k];
                sel_last  = in_last[k];
            end
        end
    end

    // Pack per-stream counts into the trailer, upper bits zero.
    always_comb begin
        trailer_word = '0;
        for (int k = 0; k < int'(NUM_STREAMS); k++) begin
            trailer_word[k*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[k];
        end
    end

    assign beat_hs = (state_q == ST_READOUT) & sel_valid & out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and readout datapath outputs.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        enter_capture = 1'b0;
        leave_capture = 1'b0;
        out_data      = '0;
        out_valid     = 1'b0;
        out_last      = 1'b0;
        in_ready      = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    state_d       = ST_CAPTURE;
                    enter_capture = 1'b1;
                end else if (cmd_arm) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (cmd_stop) begin
                    state_d = ST_IDLE;
                end else if (cmd_start || trig) begin
                    state_d       = ST_CAPTURE;
                    enter_capture = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (cmd_stop || (|stream_full)) begin
                    state_d       = ST_READOUT;
                    leave_capture = 1'b1;
                    sel_d         = '0;
                end
            end
            ST_READOUT: begin
                out_data        = sel_data;
                out_valid       = sel_valid;
                in_ready[sel_q] = out_ready;
                if (beat_hs && sel_last) begin
                    if (sel_q == LAST_SEL) begin
                        state_d = ST_TRAILER;
                        sel_d   = '0;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
            end
            ST_TRAILER: begin
                out_data  = trailer_word;
                out_valid = 1'b1;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: stream select, mask, aux history, pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q          <= '0;
            mask_q         <= '1;
            aux_d_q        <= '0;
            buffer_start_q <= 1'b0;
            buffer_stop_q  <= 1'b0;
        end else begin
            sel_q          <= sel_d;
            aux_d_q        <= aux_trigger;
            buffer_start_q <= enter_capture;
            buffer_stop_q  <= leave_capture;
            if ((state_q == ST_IDLE) && mask_valid) begin
                mask_q <= mask_data;
            end
        end
    end

    // Per-stream beat counters: cleared when a window opens, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(NUM_STREAMS); k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NUM_STREAMS); k++) begin
                if (enter_capture) begin
                    cnt_q[k] <= '0;
                end else if (beat_hs && (sel_q == SEL_W'(k)) && (cnt_q[k] != '1)) begin
                    cnt_q[k] <= cnt_q[k] + COUNT_WIDTH'(1);
                end
            end
        end
    end

    assign cmd_ready    = 1'b1;
    assign mask_ready   = (state_q == ST_IDLE);
    assign buffer_start = buffer_start_q;
    assign buffer_stop  = buffer_stop_q;
    assign capture_done = (state_q == ST_READOUT) || (state_q == ST_TRAILER);
    assign state        = state_q;

endmodule

// File: tb/tb_sparse_capture_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sparse_capture_sequencer
//
// Purpose: directed plus randomized bench for sparse_capture_sequencer with
// default parameters. Readout traffic is checked against queues of the words
// each stream sent; the trailer is checked against beat counts packed with
// plain arithmetic.
// ----------------------------------------------------------------------------
module tb_sparse_capture_sequencer;

    logic         clk;
    logic         reset;
    logic [2:0]   cmd_data;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   mask_data;
    logic         mask_valid;
    logic         mask_ready;
    logic [3:0]   aux_trigger;
    logic [1:0]   stream_full;
    logic         buffer_start;
    logic         buffer_stop;
    logic         capture_done;
    logic [2:0]   state;
    logic [255:0] in_data;
    logic [1:0]   in_valid;
    logic [1:0]   in_last;
    logic [1:0]   in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    sparse_capture_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .mask_data    (mask_data),
        .mask_valid   (mask_valid),
        .mask_ready   (mask_ready),
        .aux_trigger  (aux_trigger),
        .stream_full  (stream_full),
        .buffer_start (buffer_start),
        .buffer_stop  (buffer_stop),
        .capture_done (capture_done),
        .state        (state),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] c);
        cmd_data  = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_data  = 3'b000;
    endtask

    task automatic pulse_aux(input int idx);
        aux_trigger[idx] = 1'b1;
        tick();
        aux_trigger[idx] = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drain both streams from READOUT through the trailer back to IDLE.
    task automatic run_readout(input int b0, input int b1, input bit toggle);
        logic [127:0] q0[$];
        logic [127:0] q1[$];
        logic [127:0] exp_trailer;
        logic         rdy;
        logic         exp_valid;
        logic         hs;
        int           cur;
        int           cyc;
        for (int i = 0; i < b0; i++) q0.push_back(rnd128());
        for (int i = 0; i < b1; i++) q1.push_back(rnd128());
        exp_trailer = (128'(b1) << 32) | 128'(b0);
        rdy = 1'b0;
        cyc = 0;
        while ((q0.size() + q1.size()) > 0 && cyc < 500) begin
            cur = (q0.size() > 0) ? 0 : 1;
            in_valid[0] = (q0.size() > 0) && (toggle || ($urandom % 4) != 0);
            in_valid[1] = (q1.size() > 0) && (toggle || ($urandom % 4) != 0);
            in_last[0]  = (q0.size() == 1);
            in_last[1]  = (q1.size() == 1);
            in_data[127:0]   = (q0.size() > 0) ? q0[0] : rnd128();
            in_data[255:128] = (q1.size() > 0) ? q1[0] : rnd128();
            rdy       = toggle ? ~rdy : 1'($urandom % 2);
            out_ready = rdy;
            #1;
            exp_valid = (cur == 0) ? in_valid[0] : in_valid[1];
            chk("ro_state", 128'(state), 128'(3));
            chk("ro_valid", 128'(out_valid), 128'(exp_valid));
            if (exp_valid) chk("ro_data", out_data, (cur == 0) ? q0[0] : q1[0]);
            chk("ro_last", 128'(out_last), 128'(0));
            chk("ro_in_ready", 128'(in_ready), rdy ? 128'(2'b01 << cur) : 128'(0));
            chk("ro_done", 128'(capture_done), 128'(1));
            hs = exp_valid && rdy;
            @(posedge clk);
            #1;
            if (hs) begin
                if (cur == 0) void'(q0.pop_front());
                else          void'(q1.pop_front());
            end
            cyc++;
        end
        chk("ro_drained", 128'(q0.size() + q1.size()), 128'(0));
        in_valid  = 2'b00;
        in_last   = 2'b00;
        out_ready = 1'b0;
        #1;
        chk("tr_state", 128'(state), 128'(4));
        chk("tr_valid", 128'(out_valid), 128'(1));
        chk("tr_last", 128'(out_last), 128'(1));
        chk("tr_data", out_data, exp_trailer);
        chk("tr_in_ready", 128'(in_ready), 128'(0));
        tick();
        chk("tr_stall", 128'(state), 128'(4));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("tr_exit_state", 128'(state), 128'(0));
        chk("tr_exit_valid", 128'(out_valid), 128'(0));
        chk("tr_exit_done", 128'(capture_done), 128'(0));
    endtask

    initial begin
        int r;
        reset       = 1'b1;
        cmd_data    = 3'b000;
        cmd_valid   = 1'b0;
        mask_data   = 4'b0000;
        mask_valid  = 1'b0;
        aux_trigger = 4'b0000;
        stream_full = 2'b00;
        in_data     = '0;
        in_valid    = 2'b00;
        in_last     = 2'b00;
        out_ready   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset values.
        chk("rst_state", 128'(state), 128'(0));
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("rst_mask_ready", 128'(mask_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_bstart", 128'(buffer_start), 128'(0));
        chk("rst_bstop", 128'(buffer_stop), 128'(0));
        chk("rst_done", 128'(capture_done), 128'(0));

        // All bits set: stop wins, so IDLE is kept; bare stop also ignored.
        send_cmd(3'b111);
        chk("cmd111_idle", 128'(state), 128'(0));
        send_cmd(3'b001);
        chk("stop_idle", 128'(state), 128'(0));

        // Start from IDLE.
        send_cmd(3'b010);
        chk("start_state", 128'(state), 128'(2));
        chk("start_pulse", 128'(buffer_start), 128'(1));
        tick();
        chk("start_pulse_end", 128'(buffer_start), 128'(0));
        chk("start_hold", 128'(state), 128'(2));

        // Stop command and buffer full in the same cycle.
        cmd_data    = 3'b001;
        cmd_valid   = 1'b1;
        stream_full = 2'b10;
        tick();
        cmd_valid   = 1'b0;
        stream_full = 2'b00;
        chk("dual_stop_state", 128'(state), 128'(3));
        chk("dual_stop_pulse", 128'(buffer_stop), 128'(1));
        chk("dual_stop_done", 128'(capture_done), 128'(1));
        tick();
        chk("dual_stop_once", 128'(buffer_stop), 128'(0));
        run_readout(3, 5, 1'b1);

        // Masked trigger: only aux[1] enabled, held level does not retrigger.
        mask_data  = 4'b0010;
        mask_valid = 1'b1;
        tick();
        mask_valid = 1'b0;
        aux_trigger[1] = 1'b1;
        tick();
        send_cmd(3'b100);
        chk("arm_state", 128'(state), 128'(1));
        tick();
        tick();
        chk("held_no_trig", 128'(state), 128'(1));
        pulse_aux(0);
        tick();
        chk("masked_no_trig", 128'(state), 128'(1));
        aux_trigger[1] = 1'b0;
        tick();
        aux_trigger[1] = 1'b1;
        tick();
        chk("trig_state", 128'(state), 128'(2));
        chk("trig_pulse", 128'(buffer_start), 128'(1));

        // Mask write outside IDLE is refused.
        chk("cap_mask_ready", 128'(mask_ready), 128'(0));
        mask_data  = 4'b0001;
        mask_valid = 1'b1;
        tick();
        mask_valid  = 1'b0;
        stream_full = 2'b01;
        tick();
        stream_full = 2'b00;
        chk("full_stop_state", 128'(state), 128'(3));
        chk("full_stop_pulse", 128'(buffer_stop), 128'(1));
        run_readout(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 1'b0);
        aux_trigger[1] = 1'b0;
        tick();
        send_cmd(3'b100);
        pulse_aux(0);
        tick();
        chk("mask_kept", 128'(state), 128'(1));
        send_cmd(3'b001);
        chk("armed_stop", 128'(state), 128'(0));
        send_cmd(3'b100);
        pulse_aux(1);
        chk("mask_kept_trig", 128'(state), 128'(2));

        // Reset in the middle of readout.
        send_cmd(3'b001);
        in_valid  = 2'b01;
        in_last   = 2'b00;
        in_data   = {rnd128(), rnd128()};
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_state", 128'(state), 128'(0));
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_out_data", out_data, 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
        chk("mid_rst_done", 128'(capture_done), 128'(0));
        chk("mid_rst_mask_ready", 128'(mask_ready), 128'(1));
        reset     = 1'b0;
        in_valid  = 2'b00;
        out_ready = 1'b0;
        send_cmd(3'b100);
        pulse_aux(3);
        chk("rst_mask_ones", 128'(state), 128'(2));
        send_cmd(3'b001);
        run_readout(2, 4, 1'b0);

        // Randomized windows.
        for (int n = 0; n < 8; n++) begin
            if ($urandom % 2 == 0) begin
                send_cmd(3'b010);
            end else begin
                send_cmd(3'b100);
                chk("rnd_armed", 128'(state), 128'(1));
                pulse_aux(int'($urandom_range(0, 3)));
            end
            chk("rnd_capture", 128'(state), 128'(2));
            chk("rnd_bstart", 128'(buffer_start), 128'(1));
            r = int'($urandom_range(0, 3));
            for (int i = 0; i < r; i++) tick();
            chk("rnd_capture_hold", 128'(state), 128'(2));
            if ($urandom % 2 == 0) begin
                send_cmd(3'b001);
            end else begin
                stream_full = 2'($urandom_range(1, 3));
                tick();
                stream_full = 2'b00;
            end
            chk("rnd_bstop", 128'(buffer_stop), 128'(1));
            run_readout(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 1'($urandom % 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
